// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared defaults, port indices and read-tag type for the on-chip RAM arbiter
package onchip_mem_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int DEPTH_DEF    = 50000;
  localparam int MAX_HOLD_DEF = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic oor;
  } rd_tag_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr.sv
// rtl/onchip_mem_arbiter_rr.sv - two-way round-robin grant with a consecutive-grant limit
module rr_arbiter2 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic       rr_q, rr_d;
  logic       last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       win;
  logic       both;
  logic       hold_hit;

  always_comb begin
    gnt_o    = 2'b00;
    rr_d     = rr_q;
    last_d   = last_q;
    hold_d   = 8'd0;
    both     = &req_i;
    hold_hit = (hold_q >= 8'(MAX_HOLD));
    win      = rr_q;
    if (enable_i && (req_i != 2'b00)) begin
      // Once a port has held the RAM long enough, the waiting port takes the slot.
      if (both) win = hold_hit ? ~last_q : rr_q;
      else      win = req_i[1];
      gnt_o[win] = 1'b1;
      rr_d       = ~win;
      last_d     = win;
      if (both && (win == last_q) && (hold_q != 8'd0))
        hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
      else
        hold_d = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q   <= 1'b0;
      last_q <= 1'b0;
      hold_q <= 8'd0;
    end else begin
      rr_q   <= rr_d;
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - shares one single-port on-chip RAM between the CPU data master and the audio DMA
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   p0_address,
  input  logic [DATA_W/8-1:0] p0_byteenable,
  input  logic                p0_read,
  input  logic                p0_write,
  input  logic [DATA_W-1:0]   p0_writedata,
  output logic                p0_waitrequest,
  output logic [DATA_W-1:0]   p0_readdata,
  output logic                p0_readdatavalid,
  input  logic [ADDR_W-1:0]   p1_address,
  input  logic [DATA_W/8-1:0] p1_byteenable,
  input  logic                p1_read,
  input  logic                p1_write,
  input  logic [DATA_W-1:0]   p1_writedata,
  output logic                p1_waitrequest,
  output logic [DATA_W-1:0]   p1_readdata,
  output logic                p1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                oor_error
);

  logic [1:0]          req, gnt;
  logic                grant_valid, sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_read, sel_write;
  logic                in_range;
  rd_tag_t             tag_q, tag_d;
  logic                oor_q, oor_d;
  logic [DATA_W-1:0]   rdata, p0_rd_q, p1_rd_q;
  logic                rv0, rv1;

  assign req = {p1_read | p1_write, p0_read | p0_write};

  rr_arbiter2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable_i (~reset & ~reset_req),
    .req_i    (req),
    .gnt_o    (gnt)
  );

  assign p0_waitrequest = req[0] & ~gnt[0];
  assign p1_waitrequest = req[1] & ~gnt[1];
  assign grant_valid    = |gnt;
  assign sel            = gnt[1];

  assign sel_addr       = sel ? p1_address : p0_address;
  assign sel_read       = sel ? p1_read    : p0_read;
  assign sel_write      = sel ? p1_write   : p0_write;
  assign in_range       = (33'(sel_addr) < 33'(DEPTH));

  assign mem_address    = sel_addr;
  assign mem_byteenable = sel ? p1_byteenable : p0_byteenable;
  assign mem_writedata  = sel ? p1_writedata  : p0_writedata;
  assign mem_chipselect = grant_valid & in_range & ~reset_req;
  assign mem_write      = grant_valid & sel_write & in_range;
  assign mem_clken      = ~reset_req;

  // Read+write together counts as a write, so only a pure read is tagged.
  always_comb begin
    tag_d       = '0;
    tag_d.valid = grant_valid & sel_read & ~sel_write;
    tag_d.port  = sel;
    tag_d.oor   = ~in_range;
    oor_d       = oor_q | (grant_valid & ~in_range);
  end

  assign rdata            = tag_q.oor ? '0 : mem_readdata;
  assign rv0              = tag_q.valid & (tag_q.port == PORT_CPU) & ~reset;
  assign rv1              = tag_q.valid & (tag_q.port == PORT_DMA) & ~reset;
  assign p0_readdatavalid = rv0;
  assign p1_readdatavalid = rv1;
  assign p0_readdata      = rv0 ? rdata : p0_rd_q;
  assign p1_readdata      = rv1 ? rdata : p1_rd_q;
  assign oor_error        = oor_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q   <= '0;
      oor_q   <= 1'b0;
      p0_rd_q <= '0;
      p1_rd_q <= '0;
    end else begin
      tag_q <= tag_d;
      oor_q <= oor_d;
      if (rv0) p0_rd_q <= rdata;
      if (rv1) p1_rd_q <= rdata;
    end
  end

endmodule
